// File: rtl/multi_digit_bcd_cntr_pkg.sv
// Shared definitions for the multi-digit BCD counter and its 7-segment decode.
// Segment constants are active-low, bit 6 = seg a ... bit 0 = seg g.
package multi_digit_bcd_cntr_pkg;
  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/multi_digit_bcd_cntr_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes go dark.
module seg7_decode
  import multi_digit_bcd_cntr_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/multi_digit_bcd_cntr.sv
// NUM_DIGITS BCD up/down counter with count prescaler and multiplexed
// common-anode display drive. Optional: LEADING_ZERO_BLANK_EN blanks leading zeros.
module multi_digit_bcd_cntr
  import multi_digit_bcd_cntr_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int COUNT_DIV  = 50_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    up,
  output logic [NUM_DIGITS-1:0]   a,
  output logic [6:0]              c,
  output logic                    ovf,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]                cpre;
  logic [SW-1:0]                spre;
  logic [IW-1:0]                idx;
  bcd_t [NUM_DIGITS-1:0]        dig, dig_nx;
  logic [NUM_DIGITS-1:0][6:0]   seg;
  logic [NUM_DIGITS-1:0]        lz;
  logic                         tick, sadv, wrap;

  assign tick = en && (cpre == CW'(COUNT_DIV - 1));
  assign sadv = (spre == SW'(SCAN_DIV - 1));
  assign bcd  = dig;

  // Ripple carry/borrow: the chain survives past the top digit only on wrap.
  always_comb begin
    logic cy;
    dig_nx = dig;
    cy     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (up) begin
          if (dig[i] == 4'd9) dig_nx[i] = 4'd0;
          else begin dig_nx[i] = dig[i] + 4'd1; cy = 1'b0; end
        end else begin
          if (dig[i] == 4'd0) dig_nx[i] = 4'd9;
          else begin dig_nx[i] = dig[i] - 4'd1; cy = 1'b0; end
        end
      end
    end
    wrap = cy;
  end

  // lz[i]: digit i and every more-significant digit are zero.
  always_comb begin
    logic allz;
    lz   = '0;
    allz = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allz  = allz & (dig[i] == 4'd0);
      lz[i] = allz;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (.bcd(dig[g]), .seg(seg[g]));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cpre <= '0;
      spre <= '0;
      idx  <= '0;
      dig  <= '0;
      ovf  <= 1'b0;
      a    <= ~NUM_DIGITS'(1);
      c    <= SEG_0;
    end else begin
      if (en) cpre <= tick ? '0 : cpre + 1'b1;
      spre <= sadv ? '0 : spre + 1'b1;
      if (sadv) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (tick) dig <= dig_nx;
      ovf <= tick & wrap;
      a   <= ~(NUM_DIGITS'(1) << idx);
`ifdef LEADING_ZERO_BLANK_EN
      c   <= (idx != '0 && lz[idx]) ? SEG_BLANK : seg[idx];
`else
      c   <= seg[idx];
`endif
    end
  end
endmodule

// File: doc/multi_digit_bcd_cntr.md
Name: multi_digit_bcd_cntr

Overview:
- Parametrised successor to the single-digit 7-segment counter.
- NUM_DIGITS-digit BCD up/down counter with an internal count-rate prescaler and time-multiplexed drive of a common-anode 7-segment display.
- Sits between the board clock and the display pins.
- Replaces the external slow-clock divider: everything runs on clk, using enable ticks.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and anode lines (2..8).
- COUNT_DIV, 50_000_000, clk cycles per count step (>=1).
- SCAN_DIV, 50_000, clk cycles each digit is held active during scanning (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- clr  in  1  synchronous active-high reset.
- en  in  1  count enable; 0 freezes the count prescaler and the value.
- up  in  1  direction; 1 = increment, 0 = decrement.
- a  out  NUM_DIGITS  anode selects, active-low, one-hot-zero; bit i = digit i (bit 0 = least significant).
- c  out  7  segments, active-low; c[6]=seg a ... c[0]=seg g.
- ovf  out  1  one-clk pulse on wrap in either direction.
- bcd  out  4*NUM_DIGITS  current count; digit i at bcd[4i+3:4i].

Behaviour:
- Reset (clr=1 at posedge) takes priority over all other events, including mid-scan and mid-prescale:
  - count prescaler = 0, scan prescaler = 0, scan index = 0;
  - all digits = 0, ovf = 0;
  - a = all ones except bit 0 = 0;
  - c = 7'b0000001.
- Count prescaler:
  - increments each clk while en=1 and holds while en=0.
  - When it reaches COUNT_DIV-1 with en=1, it returns to 0 and asserts an internal tick for that cycle.
- Count step on tick, ripple BCD:
  - Up: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - Down: digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - Wrap: all-9s up gives all-0s; all-0s down gives all-9s.
  - ovf=1 in the cycle after the wrapping tick, for exactly one cycle.
- up is sampled only on the tick cycle. Toggling up between ticks has no effect.
- bcd is registered and updates on the tick edge.
- Scan:
  - The scan prescaler free-runs regardless of en.
  - At SCAN_DIV-1 it returns to 0 and the scan index advances: 0,1,...,NUM_DIGITS-1,0.
- Display outputs:
  - a and c are registered from the current scan index and the current digit value, so there is 1 clk latency from an index or value change to the pins.
  - Exactly one bit of a is low at all times after reset.
- Decode (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Non-BCD values are unreachable. If decoded anyway, c=7'b1111111.
- A simultaneous tick and scan advance are both applied on the same edge. The displayed digit reflects the new value one cycle later.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - While digit i is scanned, if digit i and every more-significant digit are 0 and i != 0, then c = 7'b1111111 (segments off).
  - The anode still cycles normally.
  - Digit 0 always shows, so a count of 0 displays a single "0".
- Undefined: all digits always decoded, leading zeros shown.

Decomposition:
- Shared package holds:
  - SEG_* 7-bit active-low constants for 0..9 and SEG_BLANK;
  - the bcd-digit typedef (4 bits).
- One natural sub-module: seg7_decode (4-bit BCD in, 7-bit active-low segments out), combinational and reusable by other display blocks.
- Prescalers and the ripple BCD stay inline.

Test Plan (NUM_DIGITS=2, COUNT_DIV=4, SCAN_DIV=2 unless stated):
- clr=1 for 3 cycles, then 0 -> a=2'b10, c=7'b0000001, bcd=8'h00, ovf=0 immediately after reset edge.
- en=1, up=1, 40 clk -> bcd steps every 4 clk, reaching 8'h10 after 40 clk; 09 -> 10 carry is correct.
- Preload by counting to 8'h99, one more tick up -> bcd=8'h00, ovf high exactly 1 cycle; then up=0 for one tick -> bcd=8'h99 with an ovf pulse.
- en=0 for 20 clk mid-count -> bcd constant; a keeps alternating 10/01 every 2 clk; resuming continues from the held prescaler phase.
- bcd=8'h37 -> when a=2'b10, c=7'b0001111 (7); when a=2'b01, c=7'b0000110 (3).
- With LEADING_ZERO_BLANK_EN, bcd=8'h05 -> a=2'b01 phase shows c=7'b1111111; a=2'b10 shows 7'b0100100. Assert clr mid-scan -> reset values on the next edge.
